rr_arbiter_onehot: RTL and testbench

Round-robin arbiter that selects one of 2**W level-sensitive requesters and presents the winner as a registered one-hot grant with a valid/ready handshake. It sits directly upstream of the pipelined one-hot-to-binary encoder, which consumes `gnt` and produces the W-bit winner index. Fairness comes from a rotating priority pointer. The grant is held stable under backpressure.

---
 rtl/rr_arbiter_onehot_pkg.sv | 12 +
 rtl/rr_arbiter_onehot_pick.sv | 26 ++
 rtl/rr_arbiter_onehot.sv | 64 ++++++
 tb/tb_rr_arbiter_onehot.sv | 136 +++++++++++++
 4 files changed

// File: rtl/rr_arbiter_onehot_pkg.sv
// Shared sizing and state encoding for the round-robin one-hot arbiter.
package rr_arbiter_onehot_pkg;
    localparam int RR_W = 4;
    localparam int RR_N = 1 << RR_W;
    localparam int RR_IDXW = RR_W;

    // The state bit doubles as gnt_valid.
    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } rr_state_t;
endpackage

// File: rtl/rr_arbiter_onehot_pick.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_pick
    import rr_arbiter_onehot_pkg::*;
#(
    parameter int W = RR_W,
    parameter int N = 1 << W
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] pick_idx,
    output logic         any_req
);
    logic [W-1:0] idx;

    // Scan from farthest to nearest so the nearest set bit is the last write.
    always_comb begin
        pick_idx = '0;
        idx      = '0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = ptr + W'(i);
            if (req[idx]) pick_idx = idx;
        end
    end

    assign any_req = |req;
endmodule

// File: rtl/rr_arbiter_onehot.sv
// Round-robin arbiter with registered one-hot grant and valid/ready output.
module rr_arbiter_onehot
    import rr_arbiter_onehot_pkg::*;
#(
    parameter int W = RR_W,
    parameter int N = 1 << W
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic [N-1:0] req,
    input  logic         gnt_ready,
    output logic         gnt_valid,
    output logic [N-1:0] gnt
);
    rr_state_t    state, state_nxt;
    logic [N-1:0] gnt_q, gnt_nxt;
    logic [W-1:0] ptr, ptr_nxt;
    logic [W-1:0] pick_idx;
    logic         any_req;
    logic         load;

    rr_pick #(.W(W), .N(N)) u_pick (
        .req      (req),
        .ptr      (ptr),
        .pick_idx (pick_idx),
        .any_req  (any_req)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= IDLE;
            gnt_q <= '0;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            gnt_q <= gnt_nxt;
            ptr   <= ptr_nxt;
        end
    end

    // An offered grant is held until accepted, even if its request drops.
    always_comb begin
        load      = (state == IDLE) || gnt_ready;
        state_nxt = state;
        gnt_nxt   = gnt_q;
        ptr_nxt   = ptr;
        if (load) begin
            if (any_req) begin
                state_nxt          = OFFER;
                gnt_nxt            = '0;
                gnt_nxt[pick_idx]  = 1'b1;
                ptr_nxt            = pick_idx + W'(1);
            end else begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
            end
        end
    end

    always_comb begin
        gnt_valid = (state == OFFER);
        gnt       = gnt_q;
    end
endmodule

// File: tb/tb_rr_arbiter_onehot.sv
// Scoreboard bench for rr_arbiter_onehot against an index-level round-robin model.
module tb_rr_arbiter_onehot;
    localparam int W = 4;
    localparam int N = 16;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         gnt_ready = 1'b0;
    logic [N-1:0] req = '0;
    logic         gnt_valid;
    logic [N-1:0] gnt;

    always #5 clk = ~clk;

    rr_arbiter_onehot #(.W(W)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req       (req),
        .gnt_ready (gnt_ready),
        .gnt_valid (gnt_valid),
        .gnt       (gnt)
    );

    typedef struct packed {
        logic         v;
        logic [N-1:0] g;
        logic [W-1:0] p;
    } exp_t;

    exp_t q[$];
    int   compared = 0;
    int   mismatched = 0;

    // Reference model state: whether a grant is offered, its index, next priority.
    int   m_v = 0, m_idx = 0, m_p = 0, found;
    // Encoder-side observation of accepted grants.
    logic         vld_s = 1'b0;
    logic [N-1:0] gnt_s = '0;
    int           watch = 0, bad15 = 0, acc_idx;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
        compared++;
        if (act !== req_v) begin
            mismatched++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, req_v, $time);
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        // Downstream encoder: a grant accepted on this edge yields its index next cycle.
        if (rstn && vld_s && gnt_ready) begin
            acc_idx = -1;
            for (int k = 0; k < N; k++) if (gnt_s[k]) acc_idx = k;
            if (watch != 0 && acc_idx == 15) bad15++;
        end
        if (!rstn) begin
            m_v = 0;
            m_p = 0;
        end else if (m_v == 0 || gnt_ready) begin
            found = -1;
            for (int k = 0; k < N; k++)
                if (found < 0 && req[(m_p + k) % N]) found = (m_p + k) % N;
            if (found >= 0) begin
                m_v   = 1;
                m_idx = found;
                m_p   = (found + 1) % N;
            end else begin
                m_v = 0;
            end
        end
        e.v = (m_v != 0);
        e.g = (m_v != 0) ? (N'(1) << m_idx) : '0;
        e.p = m_p[W-1:0];
        q.push_back(e);
    end

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("gnt_valid", 32'(gnt_valid), 32'(e.v));
            chk("gnt", 32'(gnt), 32'(e.g));
            chk("ptr", 32'(dut.ptr), 32'(e.p));
            chk("onehot0", 32'($countones(gnt) <= 1), 32'd1);
        end
        vld_s = gnt_valid;
        gnt_s = gnt;
    end

    task automatic step(input logic [N-1:0] r, input logic rd, input logic rs, input int n);
        repeat (n) begin
            req       = r;
            gnt_ready = rd;
            rstn      = rs;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [N-1:0] r;
        step(16'hFFFF, 1'b0, 1'b0, 2);
        step(16'hFFFF, 1'b1, 1'b1, 1);
        step(16'h0100, 1'b1, 1'b1, 4);
        step(16'h0000, 1'b1, 1'b1, 2);
        step(16'hFFFF, 1'b1, 1'b1, 18);
        step(16'h0000, 1'b0, 1'b0, 1);
        step(16'h0014, 1'b0, 1'b1, 5);
        step(16'h0010, 1'b0, 1'b1, 3);
        step(16'h0010, 1'b1, 1'b1, 1);
        step(16'h0000, 1'b1, 1'b1, 2);
        step(16'h0000, 1'b0, 1'b1, 1);
        step(16'h0000, 1'b1, 1'b1, 1);
        step(16'h0000, 1'b0, 1'b1, 1);
        watch = 1;
        step(16'h8000, 1'b0, 1'b1, 3);
        step(16'h0000, 1'b1, 1'b0, 1);
        step(16'h0000, 1'b1, 1'b1, 3);
        watch = 0;
        chk("no_idx15_after_reset", 32'(bad15), 32'd0);
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 3))
                0:       r = N'($urandom);
                1:       r = N'(1) << $urandom_range(0, N - 1);
                2:       r = N'($urandom) & N'($urandom) & N'($urandom);
                default: r = ($urandom_range(0, 7) == 0) ? '0 : 16'hFFFF;
            endcase
            step(r, ($urandom_range(0, 3) != 0), ($urandom_range(0, 99) != 0), 1);
        end
        @(negedge clk);
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
